// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU execute unit: state encodings, default
// parameters and the decoder write code that enables register writeback.
package mmu_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] WRITE_REG = 2'b01;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MEM_RD = 3'd1;
    localparam logic [2:0] ST_MEM_WR = 3'd2;
    localparam logic [2:0] ST_WB     = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mmu_exec_unit_if.sv
// Decode-stage, register-file and local-memory signals of the MMU execute unit.
// Handshake: an instruction transfers on a rising edge where in_valid & in_ready;
// a memory request holds mem_req/addr/we/wdata stable until the edge with mem_ack.
interface mmu_exec_unit_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_st;
    logic              in_ld;
    logic              in_invalid;
    logic [3:0]        in_reg_addr;
    logic [3:0]        in_mem_addr;
    logic [1:0]        in_write;

    logic [3:0]        rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              done;
    logic              illegal;
    logic              timeout_err;

    modport slave (
        input  in_valid, in_st, in_ld, in_invalid, in_reg_addr, in_mem_addr, in_write,
        input  rf_rdata, mem_ack, mem_rdata,
        output in_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output done, illegal, timeout_err
    );

    modport master (
        output in_valid, in_st, in_ld, in_invalid, in_reg_addr, in_mem_addr, in_write,
        output rf_rdata, mem_ack, mem_rdata,
        input  in_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  done, illegal, timeout_err
    );
endinterface

// File: rtl/mmu_ack_timer.sv
// Counts cycles a memory request has waited for its acknowledge; expired
// is raised on the TIMEOUT-th waiting cycle if no ack has arrived.
module mmu_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic ack_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          running_q;

    assign expired_o = running_q && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start_i) begin
            cnt_q     <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (ack_i || expired_o) running_q <= 1'b0;
            else                    cnt_q     <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/mmu_exec_unit.sv
// MMU execute unit: runs one load, store or exchange between the register
// file and local memory per accepted instruction, then pulses done.
module mmu_exec_unit
    import mmu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mmu_exec_unit_if.slave     bus,
    output state_t             state_o
);
    state_t            state_q, state_d;
    logic [3:0]        reg_addr_q, mem_addr_q;
    logic              st_q, ld_q;
    logic [1:0]        write_q;
    logic [DATA_W-1:0] sdata_q, ldata_q;
    logic              illegal_q, tmo_q;

    logic accept, bad_instr, timer_start, timer_expired, ack;

    assign accept    = bus.in_valid && bus.in_ready;
    assign bad_instr = bus.in_invalid || (!bus.in_st && !bus.in_ld);
    // mem_ack only counts while a request is outstanding
    assign ack       = bus.mem_ack && is_mem_state(state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_instr)     state_d = ST_DONE;
                    else if (bus.in_ld) state_d = ST_MEM_RD;
                    else               state_d = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (ack)                state_d = st_q ? ST_MEM_WR : ST_WB;
                else if (timer_expired) state_d = ST_DONE;
            end
            ST_MEM_WR: begin
                if (ack)                state_d = ld_q ? ST_WB : ST_DONE;
                else if (timer_expired) state_d = ST_DONE;
            end
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Restart the wait count on every entry into a memory state, including RD->WR.
    assign timer_start = is_mem_state(state_d) && (state_d != state_q);

    mmu_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (timer_start),
        .ack_i     (ack),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            st_q       <= 1'b0;
            ld_q       <= 1'b0;
            write_q    <= '0;
            sdata_q    <= '0;
            ldata_q    <= '0;
            illegal_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                reg_addr_q <= bus.in_reg_addr;
                mem_addr_q <= bus.in_mem_addr;
                st_q       <= bus.in_st;
                ld_q       <= bus.in_ld;
                write_q    <= bus.in_write;
                sdata_q    <= bus.rf_rdata;
                illegal_q  <= bad_instr;
                tmo_q      <= 1'b0;
            end
            if (state_q == ST_MEM_RD && ack) ldata_q <= bus.mem_rdata;
            if (is_mem_state(state_q) && !ack && timer_expired) tmo_q <= 1'b1;
        end
    end

    assign state_o         = state_q;
    assign bus.in_ready    = (state_q == ST_IDLE) && !reset;
    assign bus.rf_raddr    = bus.in_reg_addr;
    assign bus.rf_we       = (state_q == ST_WB) && (write_q == WRITE_REG);
    assign bus.rf_waddr    = reg_addr_q;
    assign bus.rf_wdata    = ldata_q;
    assign bus.mem_req     = is_mem_state(state_q);
    assign bus.mem_we      = (state_q == ST_MEM_WR);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = sdata_q;
    assign bus.done        = (state_q == ST_WB) || (state_q == ST_DONE);
    assign bus.illegal     = (state_q == ST_DONE) && illegal_q;
    assign bus.timeout_err = (state_q == ST_DONE) && tmo_q;
endmodule

// File: tb/tb_mmu_exec_unit.sv
// Directed testbench for mmu_exec_unit: one task per scenario, inline checks.
module tb_mmu_exec_unit;
  import mmu_pkg::*;

  localparam int DW = 32;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  state_t state;
  int checks = 0;
  int failures = 0;

  mmu_exec_unit_if #(.DATA_W(DW)) bus ();

  mmu_exec_unit #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state)
  );

  always #5 clk = ~clk;

  // outputs are sampled 1ns after the rising edge, inputs driven at the same point
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_st = 0; bus.in_ld = 0; bus.in_invalid = 0;
    bus.in_reg_addr = 0; bus.in_mem_addr = 0; bus.in_write = 0;
    bus.rf_rdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
  endtask

  task automatic issue(input logic st, input logic ld, input logic inv,
                       input logic [3:0] ra, input logic [3:0] ma,
                       input logic [1:0] wr, input logic [DW-1:0] rdata);
    bus.in_valid = 1; bus.in_st = st; bus.in_ld = ld; bus.in_invalid = inv;
    bus.in_reg_addr = ra; bus.in_mem_addr = ma; bus.in_write = wr; bus.rf_rdata = rdata;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL issue_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.rf_raddr !== ra) begin
      failures++; $display("FAIL rf_raddr: got %0d want %0d", bus.rf_raddr, ra);
    end
    step();
    bus.in_valid = 0;
    bus.rf_rdata = 32'h5555_AAAA;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    checks++;
    if ({bus.in_ready, bus.rf_we, bus.mem_req, bus.mem_we, bus.done, bus.illegal, bus.timeout_err} !== 7'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 0000000",
        {bus.in_ready, bus.rf_we, bus.mem_req, bus.mem_we, bus.done, bus.illegal, bus.timeout_err});
    end
    checks++;
    if (bus.mem_addr !== 4'd0 || bus.rf_waddr !== 4'd0 || bus.mem_wdata !== '0 || bus.rf_wdata !== '0) begin
      failures++; $display("FAIL reset_regs: addr %0d/%0d data %h/%h want 0",
        bus.mem_addr, bus.rf_waddr, bus.mem_wdata, bus.rf_wdata);
    end
    checks++;
    if (state !== ST_IDLE) begin
      failures++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE);
    end
    reset = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_load();
    issue(0, 1, 0, 4'd3, 4'd5, 2'b01, 32'h0);
    checks++;
    if (bus.mem_req !== 1 || bus.mem_we !== 0 || bus.mem_addr !== 4'd5 || bus.in_ready !== 0) begin
      failures++; $display("FAIL load_req: req %b we %b addr %0d ready %b want 1 0 5 0",
        bus.mem_req, bus.mem_we, bus.mem_addr, bus.in_ready);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ack = 0; bus.mem_rdata = 0;
    checks++;
    if (bus.rf_we !== 1 || bus.rf_waddr !== 4'd3 || bus.rf_wdata !== 32'hDEAD_BEEF || bus.done !== 1) begin
      failures++; $display("FAIL load_wb: we %b waddr %0d wdata %h done %b want 1 3 deadbeef 1",
        bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done);
    end
    checks++;
    if (bus.mem_req !== 0 || bus.illegal !== 0 || bus.timeout_err !== 0) begin
      failures++; $display("FAIL load_wb_misc: req %b ill %b tmo %b want 0 0 0",
        bus.mem_req, bus.illegal, bus.timeout_err);
    end
    step();
    checks++;
    if (bus.done !== 0 || bus.rf_we !== 0 || bus.in_ready !== 1) begin
      failures++; $display("FAIL load_end: done %b we %b ready %b want 0 0 1",
        bus.done, bus.rf_we, bus.in_ready);
    end
  endtask

  task automatic test_store_delayed();
    int bad = 0;
    issue(1, 0, 0, 4'd7, 4'd2, 2'b00, 32'h1234_5678);
    for (int c = 0; c < 5; c++) begin
      if (bus.mem_req !== 1 || bus.mem_we !== 1 || bus.mem_addr !== 4'd2 ||
          bus.mem_wdata !== 32'h1234_5678 || bus.done !== 0 || bus.rf_we !== 0) bad++;
      if (c == 4) bus.mem_ack = 1;
      step();
    end
    bus.mem_ack = 0;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL store_stable: %0d unstable cycles want 0", bad);
    end
    checks++;
    if (bus.done !== 1 || bus.rf_we !== 0 || bus.mem_req !== 0 || bus.illegal !== 0) begin
      failures++; $display("FAIL store_done: done %b we %b req %b ill %b want 1 0 0 0",
        bus.done, bus.rf_we, bus.mem_req, bus.illegal);
    end
    step();
    checks++;
    if (bus.done !== 0) begin
      failures++; $display("FAIL store_done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_exchange();
    issue(1, 1, 0, 4'd1, 4'd9, 2'b01, 32'hA);
    checks++;
    if (bus.mem_req !== 1 || bus.mem_we !== 0 || bus.mem_addr !== 4'd9) begin
      failures++; $display("FAIL xchg_rd: req %b we %b addr %0d want 1 0 9",
        bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'hB;
    step();
    bus.mem_rdata = 32'hFFFF_0000;
    checks++;
    if (bus.mem_req !== 1 || bus.mem_we !== 1 || bus.mem_addr !== 4'd9 || bus.mem_wdata !== 32'hA || bus.done !== 0) begin
      failures++; $display("FAIL xchg_wr: req %b we %b addr %0d wdata %h done %b want 1 1 9 a 0",
        bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done);
    end
    step();
    bus.mem_ack = 0;
    checks++;
    if (bus.rf_we !== 1 || bus.rf_waddr !== 4'd1 || bus.rf_wdata !== 32'hB || bus.done !== 1 || bus.mem_req !== 0) begin
      failures++; $display("FAIL xchg_wb: we %b waddr %0d wdata %h done %b req %b want 1 1 b 1 0",
        bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done, bus.mem_req);
    end
    step();
  endtask

  task automatic test_illegal();
    logic [1:0] variants [2] = '{2'b11, 2'b00};
    for (int v = 0; v < 2; v++) begin
      // a stray ack while idle must not start anything
      bus.mem_ack = 1;
      step();
      bus.mem_ack = 0;
      checks++;
      if (bus.mem_req !== 0 || bus.done !== 0 || bus.in_ready !== 1) begin
        failures++; $display("FAIL stray_ack: req %b done %b ready %b want 0 0 1",
          bus.mem_req, bus.done, bus.in_ready);
      end
      if (v == 0) issue(1, 1, 1, 4'd4, 4'd4, 2'b01, 32'h1);
      else        issue(0, 0, 0, 4'd4, 4'd4, 2'b01, 32'h1);
      checks++;
      if (bus.done !== 1 || bus.illegal !== 1 || bus.mem_req !== 0 || bus.rf_we !== 0 || bus.timeout_err !== 0) begin
        failures++; $display("FAIL illegal_%b: done %b ill %b req %b we %b tmo %b want 1 1 0 0 0",
          variants[v], bus.done, bus.illegal, bus.mem_req, bus.rf_we, bus.timeout_err);
      end
      step();
      checks++;
      if (bus.done !== 0 || bus.illegal !== 0) begin
        failures++; $display("FAIL illegal_pulse: done %b ill %b want 0 0", bus.done, bus.illegal);
      end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    issue(0, 1, 0, 4'd6, 4'd8, 2'b01, 32'h0);
    while (bus.mem_req === 1 && req_cycles < 40) begin
      req_cycles++;
      step();
    end
    checks++;
    if (req_cycles != TMO) begin
      failures++; $display("FAIL timeout_len: got %0d req cycles want %0d", req_cycles, TMO);
    end
    checks++;
    if (bus.done !== 1 || bus.timeout_err !== 1 || bus.rf_we !== 0 || bus.illegal !== 0) begin
      failures++; $display("FAIL timeout_done: done %b tmo %b we %b ill %b want 1 1 0 0",
        bus.done, bus.timeout_err, bus.rf_we, bus.illegal);
    end
    step();
    checks++;
    if (bus.done !== 0 || bus.timeout_err !== 0 || bus.in_ready !== 1) begin
      failures++; $display("FAIL timeout_end: done %b tmo %b ready %b want 0 0 1",
        bus.done, bus.timeout_err, bus.in_ready);
    end
  endtask

  task automatic test_load_nowb();
    issue(0, 1, 0, 4'd2, 4'd3, 2'b00, 32'h0);
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_ack = 0;
    checks++;
    if (bus.done !== 1 || bus.rf_we !== 0 || bus.timeout_err !== 0) begin
      failures++; $display("FAIL load_nowb: done %b we %b tmo %b want 1 0 0",
        bus.done, bus.rf_we, bus.timeout_err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    issue(1, 0, 0, 4'd5, 4'd11, 2'b00, 32'h7777);
    step();
    reset = 1;
    #1;
    checks++;
    if (bus.in_ready !== 0 || bus.mem_req !== 1) begin
      failures++; $display("FAIL reset_mid_pre: ready %b req %b want 0 1", bus.in_ready, bus.mem_req);
    end
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0;
    checks++;
    if (bus.mem_req !== 0 || bus.done !== 0 || bus.rf_we !== 0 || bus.in_ready !== 0) begin
      failures++; $display("FAIL reset_mid_abort: req %b done %b we %b ready %b want 0 0 0 0",
        bus.mem_req, bus.done, bus.rf_we, bus.in_ready);
    end
    reset = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1) begin
      failures++; $display("FAIL reset_mid_ready: got %b want 1", bus.in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.done !== 0 || bus.mem_req !== 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL reset_mid_quiet: %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    issue(0, 1, 0, 4'd10, 4'd1, 2'b01, 32'h0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0111;
    step();
    bus.mem_ack = 0;
    step();
    issue(1, 1, 0, 4'd12, 4'd13, 2'b01, 32'h0000_0222);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0333;
    step(); step();
    bus.mem_ack = 0;
    checks++;
    if (bus.rf_we !== 1 || bus.rf_waddr !== 4'd12 || bus.rf_wdata !== 32'h333) begin
      failures++; $display("FAIL b2b_wb: we %b waddr %0d wdata %h want 1 12 333",
        bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store_delayed();
    test_exchange();
    test_illegal();
    test_timeout();
    test_load_nowb();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
